// File: rtl/elastic_pipe_pkg.sv
// Shared definitions for the elastic_pipe valid/ready delay line.
package elastic_pipe_pkg;

    // Width of an occupancy counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/elastic_pipe_if.sv
// One valid/ready/data channel; master drives valid/data, slave drives ready.
interface elastic_pipe_if #(
    parameter int unsigned DATAW = 32
);
    logic             valid;
    logic             ready;
    logic [DATAW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/elastic_pipe_stage.sv
// Single elastic stage: one data word plus its valid bit; flush clears valid only.
module elastic_stage #(
    parameter int unsigned DATAW = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             load,
    input  logic             prev_valid,
    input  logic [DATAW-1:0] prev_data,
    output logic             valid,
    output logic [DATAW-1:0] data
);
    logic             r_valid;
    logic [DATAW-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= prev_valid;
            r_data  <= prev_data;
        end
    end

    assign valid = r_valid;
    assign data  = r_data;
endmodule

// File: rtl/elastic_pipe.sv
// Elastic valid/ready delay line of DEPTH stages with bubble collapse.
// Optional occupancy counter enabled by `define ELASTIC_PIPE_COUNT_EN.
module elastic_pipe
    import elastic_pipe_pkg::*;
#(
    parameter  int unsigned DATAW = 32,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = clog2_min1(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    elastic_pipe_if.slave  up,
    elastic_pipe_if.master dn,
    output logic [CW-1:0] count
);
    if (DEPTH == 0) begin : g_pass
        assign dn.valid = up.valid;
        assign dn.data  = up.data;
        assign up.ready = dn.ready && !flush;
        assign count    = '0;
    end else begin : g_pipe
        logic             w_valid   [DEPTH];
        logic [DATAW-1:0] w_data    [DEPTH];
        logic             w_nxt_rdy [DEPTH];
        logic             w_load    [DEPTH];
        logic             w_in_ready;
        logic             w_push;
        logic             w_pop;

        // Ready ripples backwards: a stage may advance if its successor is empty or advancing.
        for (genvar i = 0; i < DEPTH; i++) begin : g_stage
            if (i == DEPTH - 1) begin : g_last
                assign w_nxt_rdy[i] = dn.ready;
            end else begin : g_mid
                assign w_nxt_rdy[i] = !w_valid[i+1] || w_nxt_rdy[i+1];
            end
            assign w_load[i] = !w_valid[i] || w_nxt_rdy[i];

            if (i == 0) begin : g_head
                elastic_stage #(.DATAW(DATAW)) u_stage (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .flush      (flush),
                    .load       (w_load[i]),
                    .prev_valid (w_push),
                    .prev_data  (up.data),
                    .valid      (w_valid[i]),
                    .data       (w_data[i])
                );
            end else begin : g_body
                elastic_stage #(.DATAW(DATAW)) u_stage (
                    .clk        (clk),
                    .rst_n      (rst_n),
                    .flush      (flush),
                    .load       (w_load[i]),
                    .prev_valid (w_valid[i-1]),
                    .prev_data  (w_data[i-1]),
                    .valid      (w_valid[i]),
                    .data       (w_data[i])
                );
            end
        end

        assign w_in_ready = w_load[0] && !flush;
        assign w_push     = up.valid && w_in_ready;
        assign w_pop      = w_valid[DEPTH-1] && dn.ready;
        assign up.ready   = w_in_ready;
        assign dn.valid   = w_valid[DEPTH-1];
        assign dn.data    = w_data[DEPTH-1];

`ifdef ELASTIC_PIPE_COUNT_EN
        logic [CW-1:0] r_count;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_count <= '0;
            end else if (flush) begin
                r_count <= '0;
            end else begin
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        assign count = r_count;
`else
        assign count = '0;
`endif
    end
endmodule

// File: tb/tb_elastic_pipe.sv
// Randomized self-checking bench: DEPTH=3 and DEPTH=0 pipes against a slot-position model.
module tb_elastic_pipe;
    import elastic_pipe_pkg::*;

    localparam int unsigned D   = 3;
    localparam int unsigned DW  = 8;
    localparam int unsigned CWA = clog2_min1(D + 1);
    localparam int unsigned CWB = clog2_min1(1);

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          iv    = 1'b0;
    logic          ordy  = 1'b0;
    logic          fl    = 1'b0;
    logic [DW-1:0] id    = '0;
    logic [CWA-1:0] a_cnt;
    logic [CWB-1:0] b_cnt;

    always #5 clk = ~clk;

    elastic_pipe_if #(.DATAW(DW)) a_in ();
    elastic_pipe_if #(.DATAW(DW)) a_out ();
    elastic_pipe_if #(.DATAW(DW)) b_in ();
    elastic_pipe_if #(.DATAW(DW)) b_out ();

    assign a_in.valid  = iv;
    assign a_in.data   = id;
    assign a_out.ready = ordy;
    assign b_in.valid  = iv;
    assign b_in.data   = id;
    assign b_out.ready = ordy;

    elastic_pipe #(.DATAW(DW), .DEPTH(D)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fl),
        .up    (a_in),
        .dn    (a_out),
        .count (a_cnt)
    );

    elastic_pipe #(.DATAW(DW), .DEPTH(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fl),
        .up    (b_in),
        .dn    (b_out),
        .count (b_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: words oldest-first, each tagged with the slot it occupies (0..D-1).
    int            m_pos[$];
    logic [DW-1:0] m_dat[$];
    int            m_np[$];
    logic          m_ov, m_ir;
    logic [DW-1:0] m_od;

    task automatic model_eval();
        int limit;
        limit = D;
        m_np  = {};
        m_ov  = (m_pos.size() > 0) && (m_pos[0] == D - 1);
        m_od  = m_ov ? m_dat[0] : '0;
        foreach (m_pos[k]) begin
            int p;
            p = m_pos[k];
            if (p == D - 1 && ordy) begin
                m_np.push_back(-1);
            end else begin
                if (p + 1 < limit) p++;
                m_np.push_back(p);
                limit = p;
            end
        end
        m_ir = !fl && (limit > 0);
    endtask

    task automatic model_step();
        int            np[$];
        logic [DW-1:0] nd[$];
        if (fl) begin
            m_pos = {};
            m_dat = {};
        end else begin
            foreach (m_np[k]) begin
                if (m_np[k] >= 0) begin
                    np.push_back(m_np[k]);
                    nd.push_back(m_dat[k]);
                end
            end
            if (iv && m_ir) begin
                np.push_back(0);
                nd.push_back(id);
            end
            m_pos = np;
            m_dat = nd;
        end
    endtask

    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
        @(negedge clk);
        iv = v; id = d; ordy = r; fl = f;
        #1;
        model_eval();
        check("a_in_ready", 32'(a_in.ready), 32'(m_ir));
        check("a_out_valid", 32'(a_out.valid), 32'(m_ov));
        if (m_ov) check("a_out_data", 32'(a_out.data), 32'(m_od));
`ifdef ELASTIC_PIPE_COUNT_EN
        check("a_count", 32'(a_cnt), 32'(m_pos.size()));
`else
        check("a_count", 32'(a_cnt), 32'd0);
`endif
        check("b_out_valid", 32'(b_out.valid), 32'(v));
        check("b_out_data", 32'(b_out.data), 32'(d));
        check("b_in_ready", 32'(b_in.ready), 32'(r && !f));
        check("b_count", 32'(b_cnt), 32'd0);
        @(posedge clk);
        model_step();
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(a_out.valid), 32'd0);
        check("rst_out_data", 32'(a_out.data), 32'd0);
        check("rst_count", 32'(a_cnt), 32'd0);
        m_pos = {};
        m_dat = {};
        @(negedge clk);
        iv = 1'b0; ordy = 1'b0; fl = 1'b0;
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(a_in.ready), 32'd1);
    endtask

    initial begin
        #12;
        check("por_out_valid", 32'(a_out.valid), 32'd0);
        check("por_count", 32'(a_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Streaming with downstream always ready
        cycle(1, 8'h11, 1, 0); cycle(1, 8'h22, 1, 0);
        cycle(1, 8'h33, 1, 0); cycle(1, 8'h44, 1, 0);
        repeat (5) cycle(0, 8'h00, 1, 0);

        // Bubble collapse, fill to full, then gap-free drain
        cycle(1, 8'hA1, 0, 0); cycle(0, 8'h00, 0, 0);
        cycle(1, 8'hA2, 0, 0); cycle(1, 8'hA3, 0, 0);
        cycle(1, 8'hBB, 0, 0);
        repeat (4) cycle(0, 8'h00, 1, 0);

        // Full with simultaneous push and pop
        cycle(1, 8'hC1, 0, 0); cycle(1, 8'hC2, 0, 0); cycle(1, 8'hC3, 0, 0);
        cycle(1, 8'h55, 1, 0);
        repeat (5) cycle(0, 8'h00, 1, 0);

        // Flush discards stored words and blocks the concurrent push
        cycle(1, 8'h01, 0, 0); cycle(1, 8'h02, 0, 0);
        cycle(1, 8'h03, 0, 1);
        repeat (4) cycle(0, 8'h00, 1, 0);

        // Zero-depth pass-through with toggling downstream ready
        for (int i = 0; i < 4; i++) cycle(1, 8'hFE, i[0], 0);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 1'($urandom),
                  $urandom_range(0, 31) == 0);
            if (i == 300) async_reset();
        end
        repeat (5) cycle(0, 8'h00, 1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
